// File: rtl/steer_pkg.sv
// rtl/steer_pkg.sv - shared types and constants for the steering-enable controller
// Settle width follows STEER_EN_FAST_SIM_EN (short simulation settle when defined).
package steer_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT  = 2'd1,
    STEER = 2'd2
  } steer_state_t;

  localparam logic [11:0] MIN_RIDER_WT_DEF = 12'h200;
  localparam logic [11:0] WT_HYST_DEF      = 12'h040;

  localparam int TMR_W_FAST = 15;
  localparam int TMR_W_FULL = 26;

`ifdef STEER_EN_FAST_SIM_EN
  localparam int TMR_W_DEF = TMR_W_FAST;
`else
  localparam int TMR_W_DEF = TMR_W_FULL;
`endif

endpackage

// File: rtl/steer_en_sm_if.sv
// rtl/steer_en_sm_if.sv - load-cell inputs and steering/rider status outputs
interface steer_en_sm_if;

  logic [11:0] lft_ld;
  logic [11:0] rght_ld;
  logic        en_steer;
  logic        rider_off;

  modport master (output lft_ld, output rght_ld, input en_steer, input rider_off);
  modport slave  (input lft_ld, input rght_ld, output en_steer, output rider_off);

endinterface

// File: rtl/steer_ld_cmp.sv
// rtl/steer_ld_cmp.sv - registered weight and balance comparators for the load cells
module steer_ld_cmp #(
  parameter logic [11:0] MIN_RIDER_WT = 12'h200,
  parameter logic [11:0] WT_HYST      = 12'h040
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [11:0] i_lft_ld,
  input  logic [11:0] i_rght_ld,
  output logic        o_sum_gt_min,
  output logic        o_sum_lt_min,
  output logic        o_diff_gt_1_4,
  output logic        o_diff_gt_15_16
);

  localparam logic [11:0] C_OFF_12 = MIN_RIDER_WT - WT_HYST;
  localparam logic [12:0] C_MIN    = {1'b0, MIN_RIDER_WT};
  localparam logic [12:0] C_OFF    = {1'b0, C_OFF_12};

  logic [12:0] w_sum;
  logic [11:0] w_diff;
  logic [12:0] w_diff_x;
  logic [12:0] w_sum_15_16;

  assign w_sum       = {1'b0, i_lft_ld} + {1'b0, i_rght_ld};
  assign w_diff      = (i_lft_ld >= i_rght_ld) ? (i_lft_ld - i_rght_ld) : (i_rght_ld - i_lft_ld);
  assign w_diff_x    = {1'b0, w_diff};
  assign w_sum_15_16 = w_sum - {4'b0, w_sum[12:4]};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      o_sum_gt_min    <= 1'b0;
      o_sum_lt_min    <= 1'b0;
      o_diff_gt_1_4   <= 1'b0;
      o_diff_gt_15_16 <= 1'b0;
    end else begin
      o_sum_gt_min    <= (w_sum > C_MIN);
      o_sum_lt_min    <= (w_sum < C_OFF);
      o_diff_gt_1_4   <= (w_diff_x > {2'b0, w_sum[12:2]});
      o_diff_gt_15_16 <= (w_diff_x > w_sum_15_16);
    end
  end

endmodule

// File: rtl/steer_en_sm.sv
// rtl/steer_en_sm.sv - rider detection, settle timer and steering-enable state machine
// Settle length chosen by STEER_EN_FAST_SIM_EN through steer_pkg::TMR_W_DEF.
module steer_en_sm
  import steer_pkg::*;
#(
  parameter logic [11:0] MIN_RIDER_WT = MIN_RIDER_WT_DEF,
  parameter logic [11:0] WT_HYST      = WT_HYST_DEF,
  parameter int          TMR_W        = TMR_W_DEF
) (
  input  logic        clk,
  input  logic        rst,
  steer_en_sm_if.slave bus
);

  logic             w_sum_gt_min;
  logic             w_sum_lt_min;
  logic             w_diff_gt_1_4;
  logic             w_diff_gt_15_16;
  logic             w_tmr_full;
  logic [TMR_W-1:0] r_tmr;
  steer_state_t     r_state;
  steer_state_t     w_state_nxt;
  logic             r_en_steer;
  logic             r_rider_off;

  steer_ld_cmp #(
    .MIN_RIDER_WT (MIN_RIDER_WT),
    .WT_HYST      (WT_HYST)
  ) u_cmp (
    .clk             (clk),
    .rst             (rst),
    .i_lft_ld        (bus.lft_ld),
    .i_rght_ld       (bus.rght_ld),
    .o_sum_gt_min    (w_sum_gt_min),
    .o_sum_lt_min    (w_sum_lt_min),
    .o_diff_gt_1_4   (w_diff_gt_1_4),
    .o_diff_gt_15_16 (w_diff_gt_15_16)
  );

  assign w_tmr_full = &r_tmr;

  // Clearing outside WAIT makes every WAIT entry start from zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_tmr <= '0;
    end else if ((r_state != WAIT) || w_diff_gt_1_4) begin
      r_tmr <= '0;
    end else begin
      r_tmr <= r_tmr + TMR_W'(1);
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE: begin
        if (w_sum_gt_min) w_state_nxt = WAIT;
      end
      WAIT: begin
        if (w_sum_lt_min)       w_state_nxt = IDLE;
        else if (w_diff_gt_1_4) w_state_nxt = WAIT;
        else if (w_tmr_full)    w_state_nxt = STEER;
      end
      STEER: begin
        if (w_sum_lt_min)         w_state_nxt = IDLE;
        else if (w_diff_gt_15_16) w_state_nxt = WAIT;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= IDLE;
      r_en_steer  <= 1'b0;
      r_rider_off <= 1'b1;
    end else begin
      r_state     <= w_state_nxt;
      r_en_steer  <= (w_state_nxt == STEER);
      r_rider_off <= (w_state_nxt == IDLE);
    end
  end

  assign bus.en_steer  = r_en_steer;
  assign bus.rider_off = r_rider_off;

endmodule

// File: tb/tb_steer_en_sm.sv
// tb/tb_steer_en_sm.sv - self-checking bench for steer_en_sm with a behavioural rider model
module tb_steer_en_sm;

  localparam int TW      = 12;
  localparam int SETTLE  = 1 << TW;
  localparam int MIN_WT  = 'h200;
  localparam int HYST    = 'h040;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  steer_en_sm_if bus ();

  steer_en_sm #(.TMR_W(TW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Model: mode 0 = nobody on board, 1 = settling, 2 = steering.
  int          m_mode;
  int          m_cnt;
  bit          m_valid;
  int          m_l;
  int          m_r;
  wire         m_en  = (m_mode == 2);
  wire         m_off = (m_mode == 0);

  function automatic bit uneven(bit valid, int l, int r);
    int d = (l > r) ? l - r : r - l;
    return valid && (4 * d > l + r);
  endfunction

  function automatic int next_mode(int mode, int cnt, bit valid, int l, int r);
    int s    = l + r;
    int d    = (l > r) ? l - r : r - l;
    bit here = valid && (s > MIN_WT);
    bit gone = valid && (s < MIN_WT - HYST);
    bit lean = valid && (d > s - s / 16);
    case (mode)
      0:       return here ? 1 : 0;
      1:       return gone ? 0 : uneven(valid, l, r) ? 1 : (cnt == SETTLE - 1) ? 2 : 1;
      default: return gone ? 0 : lean ? 1 : 2;
    endcase
  endfunction

  function automatic int next_cnt(int mode, int nxt, int cnt, bit valid, int l, int r);
    if (mode == 1 && nxt == 1 && !uneven(valid, l, r)) return cnt + 1;
    return 0;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_mode  <= 0;
      m_cnt   <= 0;
      m_valid <= 1'b0;
      m_l     <= 0;
      m_r     <= 0;
    end else begin
      m_mode  <= next_mode(m_mode, m_cnt, m_valid, m_l, m_r);
      m_cnt   <= next_cnt(m_mode, next_mode(m_mode, m_cnt, m_valid, m_l, m_r), m_cnt, m_valid, m_l, m_r);
      m_l     <= int'(bus.lft_ld);
      m_r     <= int'(bus.rght_ld);
      m_valid <= 1'b1;
    end
  end

  task automatic tick(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic set_ld(int l, int r);
    bus.lft_ld  = 12'(l);
    bus.rght_ld = 12'(r);
  endtask

  task automatic test_reset();
    set_ld(0, 0);
    rst = 1'b1;
    tick(3);
    checks++;
    if (bus.en_steer !== 1'b0) begin
      errors++; $display("FAIL reset_en: got %0b want 0", bus.en_steer);
    end
    checks++;
    if (bus.rider_off !== 1'b1) begin
      errors++; $display("FAIL reset_off: got %0b want 1", bus.rider_off);
    end
    rst = 1'b0;
    tick(3);
    checks++;
    if (bus.rider_off !== 1'b1 || bus.en_steer !== 1'b0) begin
      errors++; $display("FAIL reset_idle: off=%0b en=%0b want off=1 en=0", bus.rider_off, bus.en_steer);
    end
  endtask

  task automatic test_balanced_mount();
    int rise = -1;
    set_ld('h180, 'h180);
    tick(1);
    checks++;
    if (bus.rider_off !== 1'b1) begin
      errors++; $display("FAIL mount_lat1: off=%0b want 1", bus.rider_off);
    end
    tick(1);
    checks++;
    if (bus.rider_off !== 1'b0 || bus.en_steer !== 1'b0) begin
      errors++; $display("FAIL mount_wait: off=%0b en=%0b want 0 0", bus.rider_off, bus.en_steer);
    end
    for (int k = 1; k <= SETTLE + 8; k++) begin
      tick(1);
      checks++;
      if (bus.en_steer !== m_en || bus.rider_off !== m_off) begin
        errors++; $display("FAIL mount_model k=%0d: en=%0b off=%0b want %0b %0b", k, bus.en_steer, bus.rider_off, m_en, m_off);
      end
      if (rise < 0 && bus.en_steer === 1'b1) rise = k;
    end
    checks++;
    if (rise != SETTLE) begin
      errors++; $display("FAIL mount_rise: rose after %0d cycles want %0d", rise, SETTLE);
    end
  endtask

  task automatic test_heavy_lean();
    set_ld('h300, 'h100);
    tick(4);
    checks++;
    if (bus.en_steer !== 1'b1 || bus.rider_off !== 1'b0) begin
      errors++; $display("FAIL lean_mild: en=%0b off=%0b want 1 0", bus.en_steer, bus.rider_off);
    end
    set_ld('h3F0, 'h010);
    tick(1);
    checks++;
    if (bus.en_steer !== 1'b1) begin
      errors++; $display("FAIL lean_lat1: en=%0b want 1", bus.en_steer);
    end
    tick(1);
    checks++;
    if (bus.en_steer !== 1'b0 || bus.rider_off !== 1'b0) begin
      errors++; $display("FAIL lean_hard: en=%0b off=%0b want 0 0", bus.en_steer, bus.rider_off);
    end
    tick(20);
    checks++;
    if (bus.en_steer !== 1'b0 || bus.rider_off !== 1'b0) begin
      errors++; $display("FAIL lean_hold: en=%0b off=%0b want 0 0", bus.en_steer, bus.rider_off);
    end
  endtask

  task automatic test_imbalance_restart();
    int rise = -1;
    set_ld('h180, 'h180);
    tick(SETTLE * 5 / 8);
    checks++;
    if (bus.en_steer !== 1'b0 || bus.rider_off !== 1'b0) begin
      errors++; $display("FAIL restart_pre: en=%0b off=%0b want 0 0", bus.en_steer, bus.rider_off);
    end
    set_ld('h300, 'h080);
    tick(10);
    set_ld('h180, 'h180);
    for (int k = 1; k <= SETTLE + 8; k++) begin
      tick(1);
      checks++;
      if (bus.en_steer !== m_en || bus.rider_off !== m_off) begin
        errors++; $display("FAIL restart_model k=%0d: en=%0b off=%0b want %0b %0b", k, bus.en_steer, bus.rider_off, m_en, m_off);
      end
      if (rise < 0 && bus.en_steer === 1'b1) rise = k;
    end
    // Flag clears one cycle after the rebalance, so the full count lands one cycle later.
    checks++;
    if (rise != SETTLE + 1) begin
      errors++; $display("FAIL restart_rise: rose after %0d cycles want %0d", rise, SETTLE + 1);
    end
  endtask

  task automatic test_reset_mid_steer();
    int rise = -1;
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if (bus.en_steer !== 1'b0 || bus.rider_off !== 1'b1) begin
      errors++; $display("FAIL async_reset: en=%0b off=%0b want 0 1", bus.en_steer, bus.rider_off);
    end
    tick(2);
    rst = 1'b0;
    tick(1);
    checks++;
    if (bus.en_steer !== 1'b0 || bus.rider_off !== 1'b1) begin
      errors++; $display("FAIL post_reset_idle: en=%0b off=%0b want 0 1", bus.en_steer, bus.rider_off);
    end
    for (int k = 1; k <= SETTLE + 8; k++) begin
      tick(1);
      checks++;
      if (bus.en_steer !== m_en || bus.rider_off !== m_off) begin
        errors++; $display("FAIL remount_model k=%0d: en=%0b off=%0b want %0b %0b", k, bus.en_steer, bus.rider_off, m_en, m_off);
      end
      if (rise < 0 && bus.en_steer === 1'b1) rise = k;
    end
    checks++;
    if (rise != SETTLE + 1) begin
      errors++; $display("FAIL remount_rise: rose after %0d cycles want %0d", rise, SETTLE + 1);
    end
  endtask

  task automatic test_hysteresis();
    set_ld('h0E8, 'h0E8);
    tick(6);
    checks++;
    if (bus.en_steer !== 1'b1 || bus.rider_off !== 1'b0) begin
      errors++; $display("FAIL hyst_hold: en=%0b off=%0b want 1 0", bus.en_steer, bus.rider_off);
    end
    set_ld('h0DF, 'h0E0);
    tick(1);
    checks++;
    if (bus.en_steer !== 1'b1) begin
      errors++; $display("FAIL hyst_lat1: en=%0b want 1", bus.en_steer);
    end
    tick(1);
    checks++;
    if (bus.en_steer !== 1'b0 || bus.rider_off !== 1'b1) begin
      errors++; $display("FAIL hyst_drop: en=%0b off=%0b want 0 1", bus.en_steer, bus.rider_off);
    end
  endtask

  task automatic test_both_events();
    set_ld('h180, 'h180);
    tick(2);
    checks++;
    if (bus.rider_off !== 1'b0 || bus.en_steer !== 1'b0) begin
      errors++; $display("FAIL both_wait: off=%0b en=%0b want 0 0", bus.rider_off, bus.en_steer);
    end
    tick(5);
    set_ld('h1A0, 'h000);
    tick(1);
    checks++;
    if (bus.rider_off !== 1'b0) begin
      errors++; $display("FAIL both_lat1: off=%0b want 0", bus.rider_off);
    end
    tick(1);
    checks++;
    if (bus.rider_off !== 1'b1 || bus.en_steer !== 1'b0) begin
      errors++; $display("FAIL both_idle: off=%0b en=%0b want 1 0", bus.rider_off, bus.en_steer);
    end
  endtask

  task automatic test_random();
    int kind, len, tot, l, r, longs;
    longs = 0;
    for (int seg = 0; seg < 160; seg++) begin
      kind = int'($urandom_range(0, 4));
      if (kind == 4 && longs >= 3) kind = 2;
      case (kind)
        0: begin l = int'($urandom_range(0, 4095)); r = int'($urandom_range(0, 4095)); end
        1: begin
          tot = int'($urandom_range('h1A0, 'h220));
          l = tot / 2 + int'($urandom_range(0, 8)) - 4;
          r = tot - l;
        end
        3: begin l = int'($urandom_range('h300, 'h7FF)); r = int'($urandom_range(0, 'h30)); end
        default: begin l = int'($urandom_range('h100, 'h400)); r = l + int'($urandom_range(0, 16)); end
      endcase
      if (kind == 4) begin
        len = SETTLE + 20;
        longs++;
      end else begin
        len = int'($urandom_range(1, 40));
      end
      set_ld(l, r);
      for (int k = 0; k < len; k++) begin
        tick(1);
        checks++;
        if (bus.en_steer !== m_en || bus.rider_off !== m_off) begin
          errors++; $display("FAIL random seg=%0d l=%0h r=%0h: en=%0b off=%0b want %0b %0b", seg, l, r, bus.en_steer, bus.rider_off, m_en, m_off);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_balanced_mount();
    test_heavy_lean();
    test_imbalance_restart();
    test_reset_mid_steer();
    test_hysteresis();
    test_both_events();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
